// File: rtl/video_capture_pkg.sv
// Shared types and constants for the video capture front end.
package video_capture_pkg;

  localparam int ADDR_W = 16;
  localparam int RGB_W  = 3;
  localparam int RGB_R  = 0;
  localparam int RGB_G  = 1;
  localparam int RGB_B  = 2;

  typedef enum logic [1:0] {
    H_WAIT,
    H_PORCH,
    H_ACTIVE,
    H_DONE
  } hstate_e;

  typedef enum logic [2:0] {
    V_WAIT,
    V_SYNC,
    V_PORCH,
    V_ACTIVE,
    V_DONE
  } vstate_e;

  // Capture RAM address layout: column in the high byte, row in the low byte.
  function automatic logic [ADDR_W-1:0] pack_addr(input logic [7:0] col, input logic [7:0] row);
    return {col, row};
  endfunction

endpackage

// File: rtl/video_capture_front_if.sv
// Write port towards the capture RAM.
interface video_capture_front_if;
  import video_capture_pkg::*;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [RGB_W-1:0]  wr_data;

  modport master (output wr_en, wr_addr, wr_data);
  modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/video_capture_front_sync_edge.sv
// Two-flop synchroniser with a third flop for rise/fall detection.
module sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q <= RESET_VAL;
      s2_q <= RESET_VAL;
      s3_q <= RESET_VAL;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;
endmodule

// File: rtl/video_capture_front.sv
// Synchronises external video syncs/pixels, tracks line/pixel position and
// issues capture-RAM writes for the active window, plus line-period lock.
module video_capture_front
  import video_capture_pkg::*;
#(
  parameter int SAMPLE_DIV = 2,
  parameter int H_BP       = 48,
  parameter int V_BP       = 33,
  parameter int CAP_W      = 256,
  parameter int CAP_H      = 256,
  parameter int LOCK_LINES = 16,
  parameter int LOCK_TOL   = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  in_hsync,
  input  logic                  in_vsync,
  input  logic [RGB_W-1:0]      in_rgb,
  video_capture_front_if.master wr_bus,
  output logic                  frame_start,
  output logic                  locked,
  output logic                  err_short
);
  localparam int DIV_W   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int MATCH_W = $clog2(LOCK_LINES + 1);

  logic hs_rise, hs_fall, vs_rise, vs_fall;
  logic [RGB_W-1:0] rgb_sync;

  // Syncs idle high, so their flops reset high to avoid a false edge at release.
  sync_edge #(.RESET_VAL(1'b1)) u_hsync (
    .clock(clock), .reset(reset), .d(in_hsync), .rise(hs_rise), .fall(hs_fall)
  );
  sync_edge #(.RESET_VAL(1'b1)) u_vsync (
    .clock(clock), .reset(reset), .d(in_vsync), .rise(vs_rise), .fall(vs_fall)
  );

  generate
    for (genvar gi = 0; gi < RGB_W; gi++) begin : g_rgb_sync
      logic meta_q, meta_d, sync_q, sync_d;
      always_comb begin
        meta_d = in_rgb[gi];
        sync_d = meta_q;
      end
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          meta_q <= 1'b0;
          sync_q <= 1'b0;
        end else begin
          meta_q <= meta_d;
          sync_q <= sync_d;
        end
      end
      assign rgb_sync[gi] = sync_q;
    end
  endgenerate

  hstate_e           hstate_q, hstate_d;
  vstate_e           vstate_q, vstate_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [15:0]       hcnt_q, hcnt_d;
  logic [15:0]       vcnt_q, vcnt_d;
  logic [7:0]        col_q, col_d;
  logic [7:0]        row_q, row_d;
  logic              frame_en_q, frame_en_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [RGB_W-1:0]  wr_data_q, wr_data_d;
  logic              frame_start_q, frame_start_d;
  logic              err_short_q, err_short_d;
  logic [15:0]       per_q, per_d;
  logic [15:0]       prev_q, prev_d;
  logic [MATCH_W-1:0] match_q, match_d;

  logic        tick, last_px, h_exit, wr_fire, per_sat;
  logic [15:0] per_diff;

  always_comb begin
    tick    = (div_q == DIV_W'(SAMPLE_DIV - 1)) && !hs_rise;
    div_d   = (hs_rise || tick) ? '0 : div_q + DIV_W'(1);
    last_px = (col_q == 8'(CAP_W - 1));
    // A sync fall on the final tick still counts as a completed line.
    h_exit  = (hstate_q == H_ACTIVE) && ((tick && last_px) || hs_fall);
    wr_fire = tick && (hstate_q == H_ACTIVE) && (vstate_q == V_ACTIVE)
              && frame_en_q && !vs_fall;
  end

  always_comb begin
    hstate_d = hstate_q;
    hcnt_d   = hcnt_q;
    col_d    = col_q;
    case (hstate_q)
      H_WAIT: begin
        if (hs_rise) begin
          hcnt_d   = '0;
          col_d    = '0;
          hstate_d = (H_BP == 0) ? H_ACTIVE : H_PORCH;
        end
      end
      H_PORCH: begin
        if (tick) begin
          if (hcnt_q == 16'(H_BP - 1)) begin
            hstate_d = H_ACTIVE;
            col_d    = '0;
          end else begin
            hcnt_d = hcnt_q + 16'd1;
          end
        end
      end
      H_ACTIVE: begin
        if (tick) begin
          col_d = col_q + 8'd1;
          if (last_px) hstate_d = H_DONE;
        end
      end
      default: ;
    endcase
    if (hs_fall) hstate_d = H_WAIT;
    err_short_d = hs_fall && (hstate_q == H_ACTIVE) && !(tick && last_px);
  end

  always_comb begin
    vstate_d      = vstate_q;
    vcnt_d        = vcnt_q;
    row_d         = row_q;
    frame_en_d    = frame_en_q;
    frame_start_d = 1'b0;
    case (vstate_q)
      V_WAIT: ;
      V_SYNC: begin
        if (vs_rise) begin
          vcnt_d   = '0;
          vstate_d = (V_BP == 0) ? V_ACTIVE : V_PORCH;
        end
      end
      V_PORCH: begin
        if (hs_rise) begin
          if (vcnt_q == 16'(V_BP - 1)) vstate_d = V_ACTIVE;
          else                         vcnt_d   = vcnt_q + 16'd1;
        end
      end
      V_ACTIVE: begin
        if (h_exit) begin
          row_d = row_q + 8'd1;
          if (row_q == 8'(CAP_H - 1)) vstate_d = V_DONE;
        end
      end
      V_DONE:  vstate_d = V_WAIT;
      default: vstate_d = V_WAIT;
    endcase
    if (vs_fall) begin
      frame_start_d = 1'b1;
      frame_en_d    = enable;
      row_d         = '0;
      vstate_d      = V_SYNC;
    end
  end

  always_comb begin
    per_sat  = (per_q == 16'hFFFF);
    per_d    = per_sat ? per_q : per_q + 16'd1;
    prev_d   = prev_q;
    match_d  = match_q;
    per_diff = (per_q >= prev_q) ? (per_q - prev_q) : (prev_q - per_q);
    if (hs_fall) begin
      per_d  = 16'd1;
      prev_d = per_q;
      if (per_diff <= 16'(LOCK_TOL)) begin
        if (match_q != MATCH_W'(LOCK_LINES)) match_d = match_q + MATCH_W'(1);
      end else begin
        match_d = '0;
      end
    end else if (per_sat) begin
      match_d = '0;
    end
  end

  always_comb begin
    wr_en_d   = wr_fire;
    wr_addr_d = wr_fire ? pack_addr(col_q, row_q) : wr_addr_q;
    wr_data_d = wr_fire ? rgb_sync : wr_data_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hstate_q      <= H_WAIT;
      vstate_q      <= V_WAIT;
      div_q         <= '0;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      col_q         <= '0;
      row_q         <= '0;
      frame_en_q    <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      frame_start_q <= 1'b0;
      err_short_q   <= 1'b0;
      per_q         <= '0;
      prev_q        <= '0;
      match_q       <= '0;
    end else begin
      hstate_q      <= hstate_d;
      vstate_q      <= vstate_d;
      div_q         <= div_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      col_q         <= col_d;
      row_q         <= row_d;
      frame_en_q    <= frame_en_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      frame_start_q <= frame_start_d;
      err_short_q   <= err_short_d;
      per_q         <= per_d;
      prev_q        <= prev_d;
      match_q       <= match_d;
    end
  end

  assign wr_bus.wr_en   = wr_en_q;
  assign wr_bus.wr_addr = wr_addr_q;
  assign wr_bus.wr_data = wr_data_q;
  assign frame_start    = frame_start_q;
  assign err_short      = err_short_q;
  // Saturation drops lock in the same cycle it is reached.
  assign locked         = (match_q == MATCH_W'(LOCK_LINES)) && !per_sat;
endmodule

// File: tb/tb_video_capture_front.sv
// Directed bench for video_capture_front with a write scoreboard.
module tb_video_capture_front;
  import video_capture_pkg::*;

  localparam int CAP_W = 8;
  localparam int CAP_H = 4;

  logic       clock = 1'b0;
  logic       reset, enable, in_hsync, in_vsync;
  logic [2:0] in_rgb;
  logic       frame_start, locked, err_short;

  video_capture_front_if wr_bus();

  video_capture_front #(
    .SAMPLE_DIV(2), .H_BP(4), .V_BP(2), .CAP_W(CAP_W), .CAP_H(CAP_H),
    .LOCK_LINES(3), .LOCK_TOL(1)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .in_hsync(in_hsync), .in_vsync(in_vsync), .in_rgb(in_rgb),
    .wr_bus(wr_bus),
    .frame_start(frame_start), .locked(locked), .err_short(err_short)
  );

  always #5 clock = ~clock;

  int n_checks = 0, n_pass = 0, n_fail = 0;
  int n_wr = 0, n_fs = 0, n_err = 0;
  int cyc = 0, last_wr_cyc = 0;
  logic [18:0] exp_q[$];
  logic [18:0] exp_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_checks++;
    assert (obs === req) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    end
  endtask

  // Output monitor: pops the scoreboard on every write.
  always @(negedge clock) begin
    cyc++;
    if (frame_start === 1'b1) begin
      n_fs++;
      check("fs_no_wr", {31'd0, wr_bus.wr_en}, 32'd0);
    end
    if (err_short === 1'b1) n_err++;
    if (wr_bus.wr_en === 1'b1) begin
      n_wr++;
      $display("wr col=%0d row=%0d r=%b g=%b b=%b", wr_bus.wr_addr[15:8], wr_bus.wr_addr[7:0],
               wr_bus.wr_data[RGB_R], wr_bus.wr_data[RGB_G], wr_bus.wr_data[RGB_B]);
      check("sb_pending", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        exp_e = exp_q.pop_front();
        check("wr_addr", {16'd0, wr_bus.wr_addr}, {16'd0, exp_e[18:3]});
        check("wr_data", {29'd0, wr_bus.wr_data}, {29'd0, exp_e[2:0]});
      end
      if (wr_bus.wr_addr[15:8] != 8'd0) check("wr_spacing", cyc - last_wr_cyc, 32'd2);
      last_wr_cyc = cyc;
    end
  end

  // One line: hsync low for lo cycles then high for hi; called on a negedge.
  task automatic line(input int lo, input int hi, input int row, input int nwr);
    if (row >= 0)
      for (int c = 0; c < nwr; c++) exp_q.push_back({8'(c), 8'(row), in_rgb});
    in_hsync = 1'b0;
    repeat (lo) @(negedge clock);
    in_hsync = 1'b1;
    repeat (hi) @(negedge clock);
  endtask

  task automatic frame(input bit cap, input int abort_row, input int en_row);
    in_vsync = 1'b0;
    line(4, 36, -1, 0);
    in_vsync = 1'b1;
    line(4, 36, -1, 0);
    for (int r = 0; r < CAP_H; r++) begin
      if (r == en_row) enable = 1'b1;
      if (r == abort_row) line(4, 21, cap ? r : -1, 6);
      else                line(4, 36, cap ? r : -1, CAP_W);
    end
    line(4, 36, -1, 0);
  endtask

  task automatic scen_end(input string tag, input int wr0, input int fs0, input int err0,
                          input int exp_wr, input int exp_fs, input int exp_err);
    repeat (4) @(negedge clock);
    check({tag, "_wr_count"}, n_wr - wr0, exp_wr);
    check({tag, "_fs_count"}, n_fs - fs0, exp_fs);
    check({tag, "_err_count"}, n_err - err0, exp_err);
    check({tag, "_sb_empty"}, exp_q.size(), 32'd0);
  endtask

  int  wr0, fs0, err0;
  bit  found;

  initial begin
    reset = 1'b1; enable = 1'b1; in_hsync = 1'b1; in_vsync = 1'b1; in_rgb = 3'b101;
    repeat (3) @(negedge clock);
    check("rst_wr_en", {31'd0, wr_bus.wr_en}, 32'd0);
    check("rst_wr_addr", {16'd0, wr_bus.wr_addr}, 32'd0);
    check("rst_wr_data", {29'd0, wr_bus.wr_data}, 32'd0);
    check("rst_frame_start", {31'd0, frame_start}, 32'd0);
    check("rst_locked", {31'd0, locked}, 32'd0);
    check("rst_err_short", {31'd0, err_short}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Nominal frame
    wr0 = n_wr; fs0 = n_fs; err0 = n_err;
    frame(1'b1, -1, -1);
    scen_end("nominal", wr0, fs0, err0, 32, 1, 0);

    // Line 1 aborted after 6 pixels
    in_rgb = 3'b011;
    wr0 = n_wr; fs0 = n_fs; err0 = n_err;
    frame(1'b1, 1, -1);
    scen_end("abort", wr0, fs0, err0, 30, 1, 1);

    // vsync falls while row 2 is due; capture restarts at row 0
    in_rgb = 3'b110;
    wr0 = n_wr; fs0 = n_fs; err0 = n_err;
    in_vsync = 1'b0; line(4, 36, -1, 0);
    in_vsync = 1'b1; line(4, 36, -1, 0);
    line(4, 36, 0, CAP_W);
    line(4, 36, 1, CAP_W);
    frame(1'b1, -1, -1);
    scen_end("vs_restart", wr0, fs0, err0, 48, 2, 0);

    // enable low at frame start, raised mid-frame
    in_rgb = 3'b001; enable = 1'b0;
    wr0 = n_wr; fs0 = n_fs; err0 = n_err;
    frame(1'b0, -1, 2);
    scen_end("en_off", wr0, fs0, err0, 0, 1, 0);
    wr0 = n_wr; fs0 = n_fs; err0 = n_err;
    frame(1'b1, -1, -1);
    scen_end("en_on", wr0, fs0, err0, 32, 1, 0);

    // Reset during H_ACTIVE of row 1
    in_rgb = 3'b111;
    wr0 = n_wr; fs0 = n_fs; err0 = n_err;
    in_vsync = 1'b0; line(4, 36, -1, 0);
    in_vsync = 1'b1; line(4, 36, -1, 0);
    line(4, 36, 0, CAP_W);
    for (int c = 0; c < 4; c++) exp_q.push_back({8'(c), 8'd1, in_rgb});
    in_hsync = 1'b0;
    repeat (4) @(negedge clock);
    in_hsync = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (wr_bus.wr_en === 1'b1 && wr_bus.wr_addr[15:8] == 8'd3) begin
        found = 1'b1;
        break;
      end
    end
    check("rst_wait_col3", {31'd0, found}, 32'd1);
    #1 reset = 1'b1;
    #1 check("rst_async_wr_en", {31'd0, wr_bus.wr_en}, 32'd0);
    check("rst_async_wr_addr", {16'd0, wr_bus.wr_addr}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    repeat (25) @(negedge clock);
    for (int l = 0; l < 6; l++) line(4, 36, -1, 0);
    check("rst_no_writes", n_wr - wr0, 32'd12);
    frame(1'b1, -1, -1);
    scen_end("rst_mid", wr0, fs0, err0, 44, 2, 0);

    // Lock: periods 40,40,41,40 then hsync held high until saturation
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (100) @(negedge clock);
    line(4, 36, -1, 0);
    line(4, 36, -1, 0);
    line(4, 37, -1, 0);
    line(4, 36, -1, 0);
    check("lock_before_third", {31'd0, locked}, 32'd0);
    in_hsync = 1'b0;
    repeat (4) @(negedge clock);
    in_hsync = 1'b1;
    repeat (4) @(negedge clock);
    check("lock_after_third", {31'd0, locked}, 32'd1);
    repeat (60000) @(negedge clock);
    check("lock_before_sat", {31'd0, locked}, 32'd1);
    repeat (10000) @(negedge clock);
    check("lock_after_sat", {31'd0, locked}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
